// File: rtl/ahb_wom_bridge_if.sv
// Bus bundle for the AHB write-only memory bridge: AHB-Lite slave side plus
// the downstream memory write port with its wready backpressure.
interface ahb_wom_bridge_if #(
    parameter int AW = 10,
    parameter int DW = 16
) ();
    localparam int NB = DW / 8;

    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;

    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NB-1:0] be;
    logic          we;
    logic          wready;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, wready,
        output HREADYOUT, HRESP, HRDATA, addr, data, be, we
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, wready,
        input  HREADYOUT, HRESP, HRDATA, addr, data, be, we
    );
endinterface

// File: rtl/ahb_wom_bridge.sv
// AHB-Lite slave that posts bus writes into a small FIFO drained onto a
// write-only memory port; reads get a fixed OKAY or two-cycle ERROR response.
module ahb_wom_bridge #(
    parameter int AW          = 10,
    parameter int DW          = 16,
    parameter int DEPTH       = 2,
    parameter int ERR_ON_READ = 1
) (
    input  logic           CLK,
    input  logic           HRESETn,
    ahb_wom_bridge_if.slave bus
);
    localparam int NB = DW / 8;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [NB-1:0] be;
    } entry_t;

    typedef enum logic [1:0] {RD_IDLE, RD_ERR1, RD_ERR2} rd_state_t;

    logic          addr_phase;
    logic          ph_valid;
    logic          ph_write;
    logic [AW-1:0] ph_addr;
    logic [2:0]    ph_size;
    logic [1:0]    ph_off;
    logic [3:0]    lane4;
    logic [NB-1:0] ph_be;
    logic          push_req, push, pop, space, stall;
    entry_t        new_entry;
    entry_t        fifo [DEPTH];
    entry_t        nxt  [DEPTH];
    logic [CW-1:0] count, nxt_count, slot;
    entry_t        out_q;
    logic          we_q;
    rd_state_t     rd_state;
    logic          err_wait, err_resp;
    logic          unused_bits;

    assign addr_phase = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ph_valid <= 1'b0;
            ph_write <= 1'b0;
            ph_addr  <= '0;
            ph_size  <= '0;
            ph_off   <= '0;
        end else if (bus.HREADY) begin
            ph_valid <= bus.HSEL & bus.HTRANS[1];
            ph_write <= bus.HWRITE;
            ph_addr  <= bus.HADDR[AW+1:2];
            ph_size  <= bus.HSIZE;
            ph_off   <= bus.HADDR[1:0];
        end
    end

    // Lanes are worked out on a 32-bit bus and then cut down to the memory width.
    always_comb begin
        lane4 = 4'b1111;
        case (ph_size)
            3'd0:    lane4 = 4'b0001 << ph_off;
            3'd1:    lane4 = ph_off[1] ? 4'b1100 : 4'b0011;
            default: lane4 = 4'b1111;
        endcase
    end

    assign ph_be     = lane4[NB-1:0];
    assign new_entry = '{addr: ph_addr, data: bus.HWDATA[DW-1:0], be: ph_be};
    assign push_req  = ph_valid & ph_write & (ph_be != '0);
    assign pop       = we_q & bus.wready;
    assign space     = (count < CW'(DEPTH)) | pop;
    assign push      = push_req & space;
    assign stall     = push_req & ~space;

    // Entry 0 is always the head; a pop shifts everything down one slot.
    always_comb begin
        nxt  = fifo;
        slot = count - CW'(pop);
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) nxt[i] = fifo[i+1];
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot == CW'(i)) nxt[i] = new_entry;
            end
        end
        nxt_count = slot + CW'(push);
    end

    always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
            count <= '0;
            we_q  <= 1'b0;
            out_q <= '0;
        end else begin
            fifo  <= nxt;
            count <= nxt_count;
            we_q  <= (nxt_count != '0);
            if (nxt_count != '0) out_q <= nxt[0];
        end
    end

    // ERR2 behaves like IDLE so a new transfer can start in the second error cycle.
    always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_state <= RD_IDLE;
            err_wait <= 1'b0;
            err_resp <= 1'b0;
        end else begin
            case (rd_state)
                RD_ERR1: begin
                    rd_state <= RD_ERR2;
                    err_wait <= 1'b0;
                    err_resp <= 1'b1;
                end
                default: begin
                    if ((ERR_ON_READ != 0) && addr_phase && !bus.HWRITE) begin
                        rd_state <= RD_ERR1;
                        err_wait <= 1'b1;
                        err_resp <= 1'b1;
                    end else begin
                        rd_state <= RD_IDLE;
                        err_wait <= 1'b0;
                        err_resp <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.HREADYOUT = ~err_wait & ~stall;
    assign bus.HRESP     = err_resp;
    assign bus.HRDATA    = '0;
    assign bus.addr      = out_q.addr;
    assign bus.data      = out_q.data;
    assign bus.be        = out_q.be;
    assign bus.we        = we_q;

    assign unused_bits = ^{bus.HADDR[31:AW+2], bus.HWDATA, bus.HTRANS[0], lane4};
endmodule
